// File: rtl/subckt_stim_driver.sv
// Stimulus driver for a 4-input sub-circuit: applies N vectors (count or LFSR order)
// and accumulates ones_count, out_toggles, in_toggles and an 8-bit MISR of n_8.
// Ports: clk, rst, start, num_vec, lfsr_mode -> n_1..n_4; n_8 response in;
//        busy, done, ones_count, out_toggles, in_toggles, signature out.
module subckt_stim_driver #(
  parameter int VEC_W = 8,
  parameter int TOG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VEC_W-1:0] num_vec,
  input  logic             lfsr_mode,
  output logic             n_1,
  output logic             n_2,
  output logic             n_3,
  output logic             n_4,
  input  logic             n_8,
  output logic             busy,
  output logic             done,
  output logic [TOG_W-1:0] ones_count,
  output logic [TOG_W-1:0] out_toggles,
  output logic [TOG_W-1:0] in_toggles,
  output logic [7:0]       signature
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [TOG_W-1:0] MAX = '1;

  state_t           state;
  logic [3:0]       v;
  logic [3:0]       v_next;
  logic [VEC_W-1:0] rem;
  logic             mode;
  logic             prev_y;
  logic             first;
  logic             last;

  assign n_1 = v[0];
  assign n_2 = v[1];
  assign n_3 = v[2];
  assign n_4 = v[3];

  // The LFSR never reaches 0000 because the run seeds it with 0001.
  always_comb begin
    v_next = v + 4'd1;
    if (mode) v_next = {v[2:0], v[3] ^ v[2]};
  end

  assign last = (rem == VEC_W'(1));

  function automatic logic [2:0] pop4(input logic [3:0] x);
    return 3'(x[0]) + 3'(x[1]) + 3'(x[2]) + 3'(x[3]);
  endfunction

  function automatic logic [TOG_W-1:0] sat_add(
    input logic [TOG_W-1:0] a,
    input logic [2:0]       b
  );
    logic [TOG_W+2:0] s;
    s = {3'b000, a} + {{TOG_W{1'b0}}, b};
    if (s > {3'b000, MAX}) return MAX;
    return s[TOG_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      v           <= 4'b0000;
      rem         <= '0;
      mode        <= 1'b0;
      prev_y      <= 1'b0;
      first       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ones_count  <= '0;
      out_toggles <= '0;
      in_toggles  <= '0;
      signature   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ones_count  <= '0;
            out_toggles <= '0;
            in_toggles  <= '0;
            signature   <= '0;
            if (num_vec == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              rem   <= num_vec;
              mode  <= lfsr_mode;
              first <= 1'b1;
              v     <= lfsr_mode ? 4'b0001 : 4'b0000;
            end
          end
        end
        RUN: begin
          // Sample the response to the vector presented this cycle.
          signature <= {signature[6:0],
                        signature[7] ^ signature[5] ^
                        signature[4] ^ signature[3] ^ n_8};
          if (n_8) ones_count <= sat_add(ones_count, 3'd1);
          if (!first && (n_8 != prev_y))
            out_toggles <= sat_add(out_toggles, 3'd1);
          prev_y <= n_8;
          first  <= 1'b0;
          if (last) begin
            // Hold the final vector on the outputs.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            in_toggles <= sat_add(in_toggles, pop4(v ^ v_next));
            v          <= v_next;
            rem        <= rem - VEC_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subckt_stim_driver.sv
// Directed bench for subckt_stim_driver: count, LFSR, N=0, ignored start,
// mid-run reset and counter saturation (second instance with TOG_W = 2).
module tb_subckt_stim_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  num_vec = '0;
  logic        lfsr_mode = 1'b0;

  logic        n_1, n_2, n_3, n_4, n_8;
  logic        busy, done;
  logic [15:0] ones_count, out_toggles, in_toggles;
  logic [7:0]  signature;

  logic        m_1, m_2, m_3, m_4, m_8;
  logic        busy2, done2;
  logic [1:0]  ones2, otog2, itog2;
  logic [7:0]  sig2;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] lfsr_tbl [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD,
                                4'hA, 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC,
                                4'h8};

  logic [3:0] vq [$];
  int         busy_cyc;
  int         done_cyc;

  always #5 clk = ~clk;

  function automatic logic ymod(input logic [3:0] x);
    return (x[0] ~^ (x[1] & x[2])) & (x[2] ^ x[3]);
  endfunction

  assign n_8 = ymod({n_4, n_3, n_2, n_1});
  assign m_8 = ymod({m_4, m_3, m_2, m_1});

  subckt_stim_driver #(.VEC_W(8), .TOG_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
    .lfsr_mode(lfsr_mode),
    .n_1(n_1), .n_2(n_2), .n_3(n_3), .n_4(n_4), .n_8(n_8),
    .busy(busy), .done(done), .ones_count(ones_count),
    .out_toggles(out_toggles), .in_toggles(in_toggles),
    .signature(signature)
  );

  subckt_stim_driver #(.VEC_W(8), .TOG_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
    .lfsr_mode(lfsr_mode),
    .n_1(m_1), .n_2(m_2), .n_3(m_3), .n_4(m_4), .n_8(m_8),
    .busy(busy2), .done(done2), .ones_count(ones2),
    .out_toggles(otog2), .in_toggles(itog2),
    .signature(sig2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_vec(input int k, input bit m);
    logic [3:0] c;
    c = 4'(k);
    if (m) return lfsr_tbl[k % 15];
    return c;
  endfunction

  function automatic int sat(input int x, input int mx);
    return (x > mx) ? mx : x;
  endfunction

  // Independent result model built from the expected vector sequence.
  task automatic model(input int n, input bit m, input int mx,
                       output int o, output int t, output int it,
                       output logic [7:0] s);
    logic [3:0] vv, pv, d;
    logic yy, py;
    o = 0; t = 0; it = 0; s = '0; pv = '0; py = 1'b0;
    for (int k = 0; k < n; k++) begin
      vv = exp_vec(k, m);
      yy = ymod(vv);
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3] ^ yy};
      if (yy) o = sat(o + 1, mx);
      if (k > 0) begin
        d = vv ^ pv;
        if (yy != py) t = sat(t + 1, mx);
        it = sat(it + int'(d[0]) + int'(d[1]) + int'(d[2]) + int'(d[3]), mx);
      end
      pv = vv;
      py = yy;
    end
  endtask

  // Launch a run, then watch n+4 cycles; optionally pulse start mid-run.
  task automatic run(input int n, input bit m, input int inject);
    vq.delete();
    busy_cyc = 0;
    done_cyc = 0;
    @(negedge clk);
    start = 1'b1;
    num_vec = 8'(n);
    lfsr_mode = m;
    @(negedge clk);
    start = 1'b0;
    num_vec = 8'hAA;
    lfsr_mode = ~m;
    for (int c = 0; c < n + 4; c++) begin
      if (busy) begin
        vq.push_back({n_4, n_3, n_2, n_1});
        busy_cyc++;
      end
      if (done) done_cyc++;
      start = (c == inject);
      if (c == inject) num_vec = 8'd3;
      @(negedge clk);
    end
    start = 1'b0;
    if (done_cyc == 0) check("run_timeout", 0, 1);
  endtask

  task automatic check_vecs(input string tag, input int n, input bit m);
    check({tag, "_nvec"}, vq.size(), n);
    for (int k = 0; k < n && k < vq.size(); k++)
      check($sformatf("%s_v%0d", tag, k), vq[k], exp_vec(k, m));
  endtask

  int e_o, e_t, e_i;
  logic [7:0] e_s;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_vec", {n_4, n_3, n_2, n_1}, 0);
    check("rst_ones", ones_count, 0);
    check("rst_sig", signature, 0);
    rst = 1'b0;

    // Count order, N = 16
    run(16, 1'b0, -1);
    check_vecs("cnt16", 16, 1'b0);
    check("cnt16_busy", busy_cyc, 16);
    check("cnt16_done", done_cyc, 1);
    check("cnt16_ones", ones_count, 4);
    check("cnt16_otog", out_toggles, 6);
    check("cnt16_itog", in_toggles, 26);
    model(16, 1'b0, 65535, e_o, e_t, e_i, e_s);
    check("cnt16_sig", signature, e_s);
    check("sat_ones", ones2, 3);
    check("sat_otog", otog2, 3);
    check("sat_itog", itog2, 3);
    check("sat_sig", sig2, e_s);

    // LFSR order, N = 20
    run(20, 1'b1, -1);
    check_vecs("lfsr20", 20, 1'b1);
    if (vq.size() >= 16) check("lfsr_v16_seed", vq[15], 4'h1);
    check("lfsr20_busy", busy_cyc, 20);
    model(20, 1'b1, 65535, e_o, e_t, e_i, e_s);
    check("lfsr20_ones", ones_count, e_o);
    check("lfsr20_otog", out_toggles, e_t);
    check("lfsr20_itog", in_toggles, e_i);
    check("lfsr20_sig", signature, e_s);
    check("lfsr20_hold", {n_4, n_3, n_2, n_1}, 4'h3);

    // N = 0
    @(negedge clk);
    start = 1'b1;
    num_vec = 8'd0;
    lfsr_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("n0_done", done, 1);
    check("n0_busy", busy, 0);
    check("n0_ones", ones_count, 0);
    check("n0_itog", in_toggles, 0);
    check("n0_sig", signature, 0);
    check("n0_vec", {n_4, n_3, n_2, n_1}, 4'h3);
    @(negedge clk);
    check("n0_done_end", done, 0);
    check("n0_busy_end", busy, 0);

    // start pulsed mid-run with num_vec = 3
    run(16, 1'b0, 5);
    check("ign_busy", busy_cyc, 16);
    check("ign_done", done_cyc, 1);
    check("ign_ones", ones_count, 4);
    check("ign_itog", in_toggles, 26);

    // reset in the middle of a run
    @(negedge clk);
    start = 1'b1;
    num_vec = 8'd16;
    lfsr_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_vec", {n_4, n_3, n_2, n_1}, 0);
    check("mrst_ones", ones_count, 0);
    check("mrst_otog", out_toggles, 0);
    check("mrst_itog", in_toggles, 0);
    check("mrst_sig", signature, 0);
    @(negedge clk);
    rst = 1'b0;
    run(4, 1'b0, -1);
    check("post_busy", busy_cyc, 4);
    check("post_ones", ones_count, 0);
    check("post_otog", out_toggles, 0);
    check("post_itog", in_toggles, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/subckt_stim_driver.md
SUBCKT_STIM_DRIVER -- requirements
Module: subckt_stim_driver

Interface
REQ-001 SHALL provide parameter VEC_W, default 8: width of the vector-count request.
REQ-002 SHALL provide parameter TOG_W, default 16: width of each result counter.
REQ-003 SHALL use one clock and one reset; reset is asynchronous and active-high.
REQ-004 SHALL have these ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a run, sampled in IDLE only.
- num_vec  input  VEC_W  number of vectors N to apply, captured with start.
- lfsr_mode  input  1  0 = binary count order, 1 = 4-bit LFSR order; captured with start.
- n_1, n_2, n_3, n_4  output  1 each  registered stimulus to the sub-circuit; n_1 = v[0], n_2 = v[1], n_3 = v[2], n_4 = v[3].
- n_8  input  1  combinational response of the sub-circuit.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.
- ones_count  output  TOG_W  number of samples with n_8 = 1.
- out_toggles  output  TOG_W  number of consecutive-sample changes of n_8.
- in_toggles  output  TOG_W  summed Hamming distance between consecutive applied vectors.
- signature  output  8  MISR of the sampled n_8 values.

Function
REQ-005 SHALL implement FSM states IDLE, RUN and DONE; IDLE is the reset state.
REQ-006 In IDLE with start = 1 and N > 0, the start edge SHALL:
- load v to 0000 when lfsr_mode = 0, or 0001 when lfsr_mode = 1;
- load the remaining count with N;
- clear all result outputs;
- enter RUN.
REQ-007 In IDLE with start = 1 and N = 0, the block SHALL:
- enter DONE and clear the results;
- leave v unchanged;
- apply no vectors.
REQ-008 Each RUN cycle SHALL present one vector; n_8 SHALL be sampled at the rising edge that ends that cycle, giving one vector per cycle and a zero-cycle response latency.
REQ-009 At each RUN edge v SHALL advance:
- count order: v + 1 mod 16;
- LFSR order: {v[2:0], v[3]^v[2]}, period 15, never 0000.
REQ-010 At the edge that takes the Nth sample the FSM SHALL go to DONE, and v SHALL hold the Nth vector.
REQ-011 DONE SHALL last exactly one cycle with done = 1, then return to IDLE; busy = 0 in IDLE and DONE.
REQ-012 ones_count SHALL increment on each sample with n_8 = 1.
REQ-013 out_toggles SHALL increment when sample k (k ≥ 2) differs from sample k-1.
REQ-014 in_toggles SHALL add popcount(v_k XOR v_(k-1)) for k ≥ 2; the transition from the pre-run v to the first vector SHALL NOT be counted.
REQ-015 All counters SHALL saturate at 2^TOG_W - 1 and never wrap.
REQ-016 signature SHALL update per sample y as sig <= {sig[6:0], sig[7]^sig[5]^sig[4]^sig[3]^y} (x^8+x^6+x^5+x^4+1).
REQ-017 Results SHALL remain stable from the final sample edge until the next accepted start.
REQ-018 start SHALL be ignored in RUN and DONE.
REQ-019 num_vec and lfsr_mode changes after the start edge SHALL have no effect on the run in progress.

Reset
REQ-020 rst SHALL immediately force the following, including in the middle of a run:
- state IDLE;
- v = 0000;
- busy = 0, done = 0;
- all counters and signature = 0.
REQ-021 The first start after rst deasserts SHALL be accepted at the first rising edge at which rst is low.

Verification
REQ-022 The bench SHALL tie n_8 to a model of y = (n_1 XNOR (n_2 & n_3)) & (n_3 XOR n_4) and cover these scenarios:
- Count mode, N = 16 → vectors 0..15, busy high 16 cycles, done pulse once; ones_count = 4, out_toggles = 6, in_toggles = 26; signature equals the bench MISR model.
- LFSR mode, N = 20 → first vector 0001, all 15 non-zero vectors before any repeat, vector 16 = 0001; counts match the bench model.
- N = 0 → done one cycle after start, busy never high, results 0, n_1..n_4 unchanged.
- start pulsed mid-run with a different num_vec → ignored; the run completes with the original N.
- rst asserted mid-run of a N = 16 run → outputs zero immediately; after release, a fresh N = 4 count-mode run yields ones_count = 0 and in_toggles = 4.
- TOG_W = 2, count mode, N = 16 → out_toggles and in_toggles saturate at 3.
